// File: rtl/sym_pkg.sv
// Shared types and constants for the symbol serializer feeding the 2-bit classifier.
package sym_pkg;

    localparam int unsigned SYM_W = 2;
    localparam logic [SYM_W-1:0] IDLE_SYM = 2'h3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Symbols per word; zero for an unusable symbol width so callers can flag it.
    function automatic int unsigned nsym(input int unsigned word_w,
                                         input int unsigned sym_w = SYM_W);
        return (sym_w == 0) ? 0 : word_w / sym_w;
    endfunction

endpackage

// File: rtl/sym_serializer_if.sv
// Word-in / symbol-out handshake bundle for sym_serializer.
interface sym_serializer_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned SYM_W  = 2
);

    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [SYM_W-1:0]  sym;
    logic              sym_valid;
    logic              sym_last;
    logic              sym_ready;

    // Environment side: supplies words and consumes symbols.
    modport master (
        output in_data, in_valid, sym_ready,
        input  in_ready, sym, sym_valid, sym_last
    );

    // Serializer side.
    modport slave (
        input  in_data, in_valid, sym_ready,
        output in_ready, sym, sym_valid, sym_last
    );

endinterface

// File: rtl/sym_serializer.sv
// Splits WORD_W-bit words into SYM_W-bit symbols, MSB first, driving IDLE_SYM
// between words so the downstream classifier can see idle cycles.
module sym_serializer #(
    parameter int unsigned      WORD_W   = 8,
    parameter int unsigned      SYM_W    = sym_pkg::SYM_W,
    parameter logic [SYM_W-1:0] IDLE_SYM = SYM_W'(sym_pkg::IDLE_SYM)
) (
    input  logic                clk,
    input  logic                rst,
    sym_serializer_if.slave     bus
);

    import sym_pkg::*;

    localparam int unsigned NSYM  = nsym(WORD_W, SYM_W);
    localparam int unsigned CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSYM - 1);
    localparam logic             ONE_SYM  = (NSYM == 1);

    generate
        if (SYM_W == 0 || WORD_W == 0 || (WORD_W % SYM_W) != 0) begin : g_bad_width
            $error("sym_serializer: WORD_W must be a nonzero multiple of SYM_W");
        end
    endgenerate

    state_e            state;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [SYM_W-1:0]  sym_q;
    logic              sym_valid_q;
    logic              sym_last_q;
    logic              accept;

    // Ready when empty, or when the last symbol leaves this cycle so words chain without a bubble.
    assign bus.in_ready = !rst && ((state == IDLE) || (sym_last_q && bus.sym_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.sym       = sym_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.sym_last  = sym_last_q;

    // shreg keeps only the symbols not yet presented on sym.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            sym_q       <= IDLE_SYM;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
        end else if (accept) begin
            state       <= SHIFT;
            shreg       <= bus.in_data << SYM_W;
            cnt         <= '0;
            sym_q       <= bus.in_data[WORD_W-1 -: SYM_W];
            sym_valid_q <= 1'b1;
            sym_last_q  <= ONE_SYM;
        end else if (state == SHIFT && bus.sym_ready) begin
            if (!sym_last_q) begin
                shreg      <= shreg << SYM_W;
                cnt        <= cnt + CNT_W'(1);
                sym_q      <= shreg[WORD_W-1 -: SYM_W];
                sym_last_q <= ((cnt + CNT_W'(1)) == LAST_CNT);
            end else begin
                state       <= IDLE;
                sym_q       <= IDLE_SYM;
                sym_valid_q <= 1'b0;
                sym_last_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sym_serializer.sv
// Directed bench for sym_serializer: 8-bit and 6-bit word configurations.
module tb_sym_serializer;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    sym_serializer_if #(.WORD_W(8), .SYM_W(2)) bus  ();
    sym_serializer_if #(.WORD_W(6), .SYM_W(2)) bus6 ();

    sym_serializer #(.WORD_W(8), .SYM_W(2), .IDLE_SYM(2'h3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sym_serializer #(.WORD_W(6), .SYM_W(2), .IDLE_SYM(2'h3)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    always #5 clk = ~clk;

    // Downstream classifier: flags symbol value 3.
    logic cls;
    assign cls = (bus.sym == 2'd3);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.in_data = 8'h00;  bus.sym_ready = 1'b1;
        bus6.in_valid = 1'b0; bus6.in_data = 6'h00; bus6.sym_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus.sym, bus.sym_valid, bus.sym_last} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_out: got sym=%0d v=%0b l=%0b want sym=3 v=0 l=0",
                     bus.sym, bus.sym_valid, bus.sym_last);
        end
        checks++;
        if ({bus6.sym, bus6.sym_valid, bus6.sym_last} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_out6: got sym=%0d v=%0b l=%0b want sym=3 v=0 l=0",
                     bus6.sym, bus6.sym_valid, bus6.sym_last);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %0b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single();
        logic [1:0] es [4];
        es = '{2'd3, 2'd2, 2'd1, 2'd0};
        bus.in_data  = 8'hE4;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) bus.in_valid = 1'b0;
            checks++;
            if ({bus.sym, bus.sym_valid, bus.sym_last} !== {es[i], 1'b1, (i == 3)}) begin
                failures++;
                $display("FAIL single_sym[%0d]: got sym=%0d v=%0b l=%0b want sym=%0d v=1 l=%0b",
                         i, bus.sym, bus.sym_valid, bus.sym_last, es[i], (i == 3));
            end
            #1;
            checks++;
            if (bus.in_ready !== (i == 3)) begin
                failures++;
                $display("FAIL single_ready[%0d]: got %0b want %0b", i, bus.in_ready, (i == 3));
            end
        end
        tick();
        checks++;
        if ({bus.sym, bus.sym_valid, bus.sym_last} !== 4'b1100) begin
            failures++;
            $display("FAIL single_idle: got sym=%0d v=%0b l=%0b want sym=3 v=0 l=0",
                     bus.sym, bus.sym_valid, bus.sym_last);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] es [8];
        es = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        bus.in_data  = 8'hE4;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) bus.in_data = 8'h1B;
            if (i == 4) bus.in_valid = 1'b0;
            checks++;
            if ({bus.sym, bus.sym_valid, bus.sym_last} !== {es[i], 1'b1, (i == 3 || i == 7)}) begin
                failures++;
                $display("FAIL b2b_sym[%0d]: got sym=%0d v=%0b l=%0b want sym=%0d v=1 l=%0b",
                         i, bus.sym, bus.sym_valid, bus.sym_last, es[i], (i == 3 || i == 7));
            end
            if (i == 3) begin
                #1;
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready_on_last: got %0b want 1", bus.in_ready);
                end
            end
        end
        tick();
        checks++;
        if ({bus.sym, bus.sym_valid} !== 3'b110) begin
            failures++;
            $display("FAIL b2b_idle: got sym=%0d v=%0b want sym=3 v=0", bus.sym, bus.sym_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.in_data  = 8'hE4;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.sym !== 2'd2) begin
            failures++;
            $display("FAIL bp_second: got sym=%0d want 2", bus.sym);
        end
        // Stall with a competing word offered; it must be ignored.
        bus.sym_ready = 1'b0;
        bus.in_data   = 8'hFF;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready[%0d]: got %0b want 0", i, bus.in_ready);
            end
            tick();
            checks++;
            if ({bus.sym, bus.sym_valid, bus.sym_last} !== 4'b1010) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got sym=%0d v=%0b l=%0b want sym=2 v=1 l=0",
                         i, bus.sym, bus.sym_valid, bus.sym_last);
            end
        end
        bus.in_valid  = 1'b0;
        bus.sym_ready = 1'b1;
        tick();
        checks++;
        if ({bus.sym, bus.sym_valid, bus.sym_last} !== 4'b0110) begin
            failures++;
            $display("FAIL bp_resume1: got sym=%0d v=%0b l=%0b want sym=1 v=1 l=0",
                     bus.sym, bus.sym_valid, bus.sym_last);
        end
        tick();
        checks++;
        if ({bus.sym, bus.sym_valid, bus.sym_last} !== 4'b0011) begin
            failures++;
            $display("FAIL bp_resume0: got sym=%0d v=%0b l=%0b want sym=0 v=1 l=1",
                     bus.sym, bus.sym_valid, bus.sym_last);
        end
        tick();
        checks++;
        if ({bus.sym, bus.sym_valid} !== 3'b110) begin
            failures++;
            $display("FAIL bp_idle: got sym=%0d v=%0b want sym=3 v=0", bus.sym, bus.sym_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        bus.in_data  = 8'hE4;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.sym !== 2'd2) begin
            failures++;
            $display("FAIL rmw_pre: got sym=%0d want 2", bus.sym);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rmw_ready_in_reset: got %0b want 0", bus.in_ready);
        end
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.sym, bus.sym_valid, bus.sym_last} !== 4'b1100) begin
            failures++;
            $display("FAIL rmw_flush: got sym=%0d v=%0b l=%0b want sym=3 v=0 l=0",
                     bus.sym, bus.sym_valid, bus.sym_last);
        end
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmw_ready_after: got %0b want 1", bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.sym, bus.sym_valid} !== 3'b110) begin
                failures++;
                $display("FAIL rmw_no_tail[%0d]: got sym=%0d v=%0b want sym=3 v=0",
                         i, bus.sym, bus.sym_valid);
            end
        end
    endtask

    task automatic test_idle_classifier();
        logic       ec [4];
        logic [1:0] es [4];
        ec = '{1'b0, 1'b0, 1'b0, 1'b1};
        es = '{2'd0, 2'd1, 2'd2, 2'd3};
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({bus.sym, bus.sym_valid, cls} !== 4'b1101) begin
                failures++;
                $display("FAIL idle[%0d]: got sym=%0d v=%0b cls=%0b want sym=3 v=0 cls=1",
                         i, bus.sym, bus.sym_valid, cls);
            end
        end
        bus.in_data  = 8'h1B;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) bus.in_valid = 1'b0;
            checks++;
            if ({bus.sym, bus.sym_valid, cls} !== {es[i], 1'b1, ec[i]}) begin
                failures++;
                $display("FAIL cls_word[%0d]: got sym=%0d v=%0b cls=%0b want sym=%0d v=1 cls=%0b",
                         i, bus.sym, bus.sym_valid, cls, es[i], ec[i]);
            end
        end
        tick();
    endtask

    task automatic test_param_word6();
        logic [1:0] es [3];
        es = '{2'd2, 2'd3, 2'd1};
        bus6.in_data  = 6'h2D;
        bus6.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) bus6.in_valid = 1'b0;
            checks++;
            if ({bus6.sym, bus6.sym_valid, bus6.sym_last} !== {es[i], 1'b1, (i == 2)}) begin
                failures++;
                $display("FAIL w6_sym[%0d]: got sym=%0d v=%0b l=%0b want sym=%0d v=1 l=%0b",
                         i, bus6.sym, bus6.sym_valid, bus6.sym_last, es[i], (i == 2));
            end
        end
        tick();
        checks++;
        if ({bus6.sym, bus6.sym_valid, bus6.sym_last} !== 4'b1100) begin
            failures++;
            $display("FAIL w6_idle: got sym=%0d v=%0b l=%0b want sym=3 v=0 l=0",
                     bus6.sym, bus6.sym_valid, bus6.sym_last);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_idle_classifier();
        test_param_word6();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
